// File: rtl/cpu_debug_jtag_master_if.sv
// Command/response bundle between a debug requester and cpu_debug_jtag_master.
// master drives commands and consumes responses; slave is the JTAG sequencer.
interface cpu_debug_jtag_master_if #(
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic                cmd_ir_only;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir;

    modport master (
        output cmd_valid, cmd_ir, cmd_ir_only, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_ir_only, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir
    );
endinterface

// File: rtl/cpu_debug_jtag_master.sv
// Virtual-JTAG initiator: turns parallel IR/DR commands into uir/cdr/sdr/udr strobes and a divided tck.
// Optional run-test-idle tail after UDR is enabled by defining CPU_DEBUG_JTAG_MASTER_RTI_EN.
module cpu_debug_jtag_master #(
    parameter int IR_WIDTH   = 2,
    parameter int DR_WIDTH   = 38,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    cpu_debug_jtag_master_if.slave bus,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);
    localparam int CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [7:0]       DIV_LAST = 8'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SHIFT,
        S_UDR,
`ifdef CPU_DEBUG_JTAG_MASTER_RTI_EN
        S_RTI,
`endif
        S_RESP
    } state_t;

    state_t               state_reg, state_next;
    logic [7:0]           div_cnt_reg;
    logic                 hi_reg;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic [DR_WIDTH-1:0]  tx_reg;
    logic [DR_WIDTH-1:0]  rx_reg;
    logic [IR_WIDTH-1:0]  ir_reg;
    logic [IR_WIDTH-1:0]  rsp_ir_reg;
    logic                 ir_only_reg;
    logic                 phase_end;
    logic                 bit_done;
    logic                 in_rti;

    assign phase_end  = (div_cnt_reg == DIV_LAST);
    assign bit_done   = phase_end && hi_reg;
    assign ir_in      = ir_reg;
    assign bus.rsp_dr = rx_reg;
    assign bus.rsp_ir = rsp_ir_reg;

`ifdef CPU_DEBUG_JTAG_MASTER_RTI_EN
    localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_CYCLES - 1);
    assign in_rti = (state_reg == S_RTI);
`else
    assign in_rti = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        bus.cmd_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        tck            = 1'b0;
        tdi            = 1'b0;
        vs_uir         = 1'b0;
        vs_cdr         = 1'b0;
        vs_sdr         = 1'b0;
        vs_udr         = 1'b0;
        jtag_state_rti = 1'b0;
        case (state_reg)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_next = S_UIR;
            end
            S_UIR: begin
                vs_uir     = 1'b1;
                state_next = ir_only_reg ? S_RESP : S_CDR;
            end
            S_CDR: begin
                vs_cdr     = 1'b1;
                tdi        = tx_reg[0];
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                vs_sdr = 1'b1;
                tck    = hi_reg;
                tdi    = tx_reg[0];
                if (bit_done && bit_cnt_reg == BIT_LAST) state_next = S_UDR;
            end
            S_UDR: begin
                vs_udr = 1'b1;
`ifdef CPU_DEBUG_JTAG_MASTER_RTI_EN
                state_next = S_RTI;
`else
                state_next = S_RESP;
`endif
            end
`ifdef CPU_DEBUG_JTAG_MASTER_RTI_EN
            S_RTI: begin
                jtag_state_rti = 1'b1;
                tck            = hi_reg;
                if (bit_done && bit_cnt_reg == RTI_LAST) state_next = S_RESP;
            end
`endif
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            div_cnt_reg <= '0;
            hi_reg      <= 1'b0;
            bit_cnt_reg <= '0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            ir_reg      <= '0;
            rsp_ir_reg  <= '0;
            ir_only_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && bus.cmd_valid) begin
                ir_reg      <= bus.cmd_ir;
                tx_reg      <= bus.cmd_dr;
                ir_only_reg <= bus.cmd_ir_only;
                rx_reg      <= '0;
            end
            if (state_reg == S_UIR) rsp_ir_reg <= ir_out;
            if (state_reg == S_CDR || state_reg == S_UDR) begin
                div_cnt_reg <= '0;
                hi_reg      <= 1'b0;
                bit_cnt_reg <= '0;
            end
            // tdo is captured as tck rises; tdi advances as tck falls into the next bit
            if (state_reg == S_SHIFT || in_rti) begin
                if (phase_end) begin
                    div_cnt_reg <= '0;
                    hi_reg      <= !hi_reg;
                    if (hi_reg) begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        if (!in_rti) tx_reg <= tx_reg >> 1;
                    end else if (!in_rti) begin
                        rx_reg <= {tdo, rx_reg[DR_WIDTH-1:1]};
                    end
                end else begin
                    div_cnt_reg <= div_cnt_reg + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu_debug_jtag_master.sv
// Directed bench for cpu_debug_jtag_master: default instance plus a TCK_DIV=1 instance.
// Expected latencies follow whether CPU_DEBUG_JTAG_MASTER_RTI_EN is defined for the build.
module tb_cpu_debug_jtag_master;
`ifdef CPU_DEBUG_JTAG_MASTER_RTI_EN
    localparam int LAT_DR = 171, RISES_DR = 42, RTI_CLKS = 16, LAT_DR1 = 87, RISES_DR1 = 42;
`else
    localparam int LAT_DR = 155, RISES_DR = 38, RTI_CLKS = 0,  LAT_DR1 = 79, RISES_DR1 = 38;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_debug_jtag_master_if #(.IR_WIDTH(2), .DR_WIDTH(38)) bus0 ();
    cpu_debug_jtag_master_if #(.IR_WIDTH(2), .DR_WIDTH(38)) bus1 ();

    logic       tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;
    logic [1:0] ir_in0;
    logic [1:0] ir_out0 = 2'b00;
    logic       tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
    logic [1:0] ir_in1;
    logic [1:0] ir_out1 = 2'b00;
    logic       loop_en = 1'b0;
    logic       tdo_val = 1'b0;

    assign tdo0 = loop_en ? tdi0 : tdo_val;
    assign tdo1 = 1'b1;

    cpu_debug_jtag_master u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .tck(tck0), .tdi(tdi0), .tdo(tdo0), .ir_in(ir_in0), .ir_out(ir_out0),
        .vs_uir(uir0), .vs_cdr(cdr0), .vs_sdr(sdr0), .vs_udr(udr0), .jtag_state_rti(rti0)
    );

    cpu_debug_jtag_master #(.TCK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .tck(tck1), .tdi(tdi1), .tdo(tdo1), .ir_in(ir_in1), .ir_out(ir_out1),
        .vs_uir(uir1), .vs_cdr(cdr1), .vs_sdr(sdr1), .vs_udr(udr1), .jtag_state_rti(rti1)
    );

    int n_vec = 0;
    int n_err = 0;
    int lat, n_uir, n_cdr, n_sdr, n_udr, n_rise, n_rti, n_excl;
    logic [1:0] uir_irin;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Issue one command on dut0 (caller sits just after a negedge) and run until rsp_valid.
    task automatic run_cmd(input logic [1:0] ir, input logic ir_only, input logic [37:0] dr);
        logic prev_tck;
        bit   done;
        bus0.cmd_ir      = ir;
        bus0.cmd_ir_only = ir_only;
        bus0.cmd_dr      = dr;
        bus0.cmd_valid   = 1'b1;
        @(posedge clk);
        lat = 0; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0;
        n_rise = 0; n_rti = 0; n_excl = 0; uir_irin = 2'b00;
        prev_tck = 1'b0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            bus0.cmd_valid = 1'b0;
            n_uir += int'(uir0);
            n_cdr += int'(cdr0);
            n_sdr += int'(sdr0);
            n_udr += int'(udr0);
            n_rti += int'(rti0);
            if (tck0 && !prev_tck) n_rise++;
            prev_tck = tck0;
            if ((int'(uir0) + int'(cdr0) + int'(udr0)) > 1 || (sdr0 && (uir0 || cdr0 || udr0)))
                n_excl++;
            if (uir0) uir_irin = ir_in0;
            if (bus0.rsp_valid) done = 1;
            else if (lat >= 1000) begin
                chk("rsp_timeout", 64'(lat), 64'd0);
                done = 1;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
    endtask

    task automatic consume0();
        bus0.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.rsp_ready = 1'b0;
    endtask

    initial begin
        int         bad, rises, tdi_hi, last_rise;
        logic       prev;
        logic [37:0] snap;
        bit         done;

        bus0.cmd_valid = 1'b0; bus0.cmd_ir = 2'b00; bus0.cmd_ir_only = 1'b0;
        bus0.cmd_dr = '0; bus0.rsp_ready = 1'b0;
        bus1.cmd_valid = 1'b0; bus1.cmd_ir = 2'b00; bus1.cmd_ir_only = 1'b0;
        bus1.cmd_dr = '0; bus1.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(bus0.cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus0.rsp_valid), 64'd0);
        chk("rst_pins", 64'({tck0, tdi0, uir0, cdr0, sdr0, udr0, rti0}), 64'd0);
        chk("rst_ir_in", 64'(ir_in0), 64'd0);
        chk("rst_rsp_dr", 64'(bus0.rsp_dr), 64'd0);
        chk("rst_rsp_ir", 64'(bus0.rsp_ir), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // IR-only command
        ir_out0 = 2'b10;
        run_cmd(2'b01, 1'b1, 38'h3F_0000_0001);
        chk("ir_latency", 64'(lat), 64'd1);
        chk("ir_uir_pulses", 64'(n_uir), 64'd1);
        chk("ir_dr_strobes", 64'(n_cdr + n_sdr + n_udr), 64'd0);
        chk("ir_in_at_uir", 64'(uir_irin), 64'd1);
        chk("ir_rsp_ir", 64'(bus0.rsp_ir), 64'd2);
        chk("ir_rsp_dr", 64'(bus0.rsp_dr), 64'd0);
        consume0();
        chk("ir_ready_after", 64'({bus0.cmd_ready, bus0.rsp_valid}), 64'b10);

        // DR loopback
        loop_en = 1'b1;
        ir_out0 = 2'b11;
        run_cmd(2'b00, 1'b0, 38'h2A_5A5A_5A5A);
        chk("dr_latency", 64'(lat), 64'(LAT_DR));
        chk("dr_tck_rises", 64'(n_rise), 64'(RISES_DR));
        chk("dr_rsp_dr", 64'(bus0.rsp_dr), 64'h2A_5A5A_5A5A);
        chk("dr_rsp_ir", 64'(bus0.rsp_ir), 64'd3);
        chk("dr_cdr_udr", 64'({n_cdr[7:0], n_udr[7:0]}), 64'h0101);
        chk("dr_sdr_clks", 64'(n_sdr), 64'd152);
        chk("dr_strobe_excl", 64'(n_excl), 64'd0);
        chk("dr_rti_clks", 64'(n_rti), 64'(RTI_CLKS));

        // Response stall with a stray command during RESP
        snap = bus0.rsp_dr;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus0.cmd_ir = 2'b10; bus0.cmd_ir_only = 1'b1; bus0.cmd_valid = 1'b1;
            end else begin
                bus0.cmd_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (bus0.rsp_valid !== 1'b1 || bus0.rsp_dr !== snap || bus0.cmd_ready !== 1'b0 || uir0)
                bad++;
        end
        bus0.cmd_valid = 1'b0;
        chk("stall_stable", 64'(bad), 64'd0);
        consume0();
        chk("stall_release", 64'({bus0.cmd_ready, bus0.rsp_valid}), 64'b10);
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (uir0 || bus0.cmd_ready !== 1'b1) bad++;
        end
        chk("no_ghost_cmd", 64'(bad), 64'd0);

        // Reset during SHIFT bit 10
        loop_en = 1'b0;
        tdo_val = 1'b1;
        bus0.cmd_ir = 2'b11; bus0.cmd_ir_only = 1'b0; bus0.cmd_dr = 38'h1; bus0.cmd_valid = 1'b1;
        @(posedge clk);
        rises = 0; prev = 1'b0; done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            bus0.cmd_valid = 1'b0;
            if (tck0 && !prev) rises++;
            prev = tck0;
            if (rises == 10 && !tck0 && sdr0) done = 1;
            else @(posedge clk);
        end
        chk("rst_reach_bit10", 64'(rises), 64'd10);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_cmd_ready", 64'({bus0.cmd_ready, bus0.rsp_valid}), 64'b10);
        chk("abort_pins", 64'({tck0, tdi0, uir0, cdr0, sdr0, udr0, rti0}), 64'd0);
        chk("abort_regs", 64'({ir_in0, bus0.rsp_ir, bus0.rsp_dr}), 64'd0);
        reset = 1'b0;
        bad = 0;
        repeat (60) begin
            @(posedge clk);
            @(negedge clk);
            bad += int'(udr0);
        end
        chk("abort_no_udr", 64'(bad), 64'd0);

        loop_en = 1'b1;
        run_cmd(2'b10, 1'b0, 38'h15_A5A5_A5A5);
        chk("post_abort_lat", 64'(lat), 64'(LAT_DR));
        chk("post_abort_dr", 64'(bus0.rsp_dr), 64'h15_A5A5_A5A5);
        consume0();

        // TCK_DIV=1 instance, tdo tied high, zero payload
        bus1.cmd_ir = 2'b00; bus1.cmd_ir_only = 1'b0; bus1.cmd_dr = '0; bus1.cmd_valid = 1'b1;
        @(posedge clk);
        lat = 0; rises = 0; tdi_hi = 0; bad = 0; last_rise = 0; prev = 1'b0; done = 0;
        while (!done) begin
            @(negedge clk);
            bus1.cmd_valid = 1'b0;
            tdi_hi += int'(tdi1);
            if (tck1 && !prev) begin
                rises++;
                if (rises > 1 && (lat - last_rise) != 2) bad++;
                last_rise = lat;
            end
            prev = tck1;
            if (bus1.rsp_valid) done = 1;
            else if (lat >= 1000) begin
                chk("div1_timeout", 64'(lat), 64'd0);
                done = 1;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
        chk("div1_latency", 64'(lat), 64'(LAT_DR1));
        chk("div1_rsp_dr", 64'(bus1.rsp_dr), 64'h3F_FFFF_FFFF);
        chk("div1_tck_rises", 64'(rises), 64'(RISES_DR1));
        chk("div1_tck_period", 64'(bad), 64'd0);
        chk("div1_tdi_zero", 64'(tdi_hi), 64'd0);
        bus1.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
        chk("div1_ready_after", 64'({bus1.cmd_ready, bus1.rsp_valid}), 64'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
